// File: rtl/reg_file_mp.sv
// Multi-port register file with x0 hardwired to zero, prioritised dual write and a busy scoreboard.
// Read data and busy flags are registered (1-cycle latency); no handshake, every port is accepted every cycle.
module reg_file_mp #(
   parameter int WORD_WIDTH     = 32,
   parameter int REG_ADDR_WIDTH = 5,
   parameter int NREAD          = 2,
   parameter bit BYPASS         = 1'b1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NREAD*REG_ADDR_WIDTH-1:0] ra,
   output logic [NREAD*WORD_WIDTH-1:0]     rd,
   output logic [NREAD-1:0]                rd_busy,
   input  logic                            w0_en,
   input  logic [REG_ADDR_WIDTH-1:0]       w0_addr,
   input  logic [WORD_WIDTH-1:0]           w0_data,
   input  logic                            w1_en,
   input  logic [REG_ADDR_WIDTH-1:0]       w1_addr,
   input  logic [WORD_WIDTH-1:0]           w1_data,
   input  logic                            mark_en,
   input  logic [REG_ADDR_WIDTH-1:0]       mark_addr,
   output logic                            busy_any
);

   localparam int NREGS = 1 << REG_ADDR_WIDTH;

   logic [WORD_WIDTH-1:0] regs_q [NREGS];
   logic [WORD_WIDTH-1:0] regs_d [NREGS];
   logic [NREGS-1:0]      busy_q;
   logic [NREGS-1:0]      busy_d;
   logic [NREGS-1:0]      busy_clr;
   logic [NREGS-1:0]      clr_mask;
   logic [NREGS-1:0]      set_mask;
   logic                  busy_any_q;
   logic                  w0_wr;
   logic                  w1_wr;
   logic                  mark_wr;

   assign w0_wr   = w0_en   && (w0_addr   != '0);
   assign w1_wr   = w1_en   && (w1_addr   != '0);
   assign mark_wr = mark_en && (mark_addr != '0);

   // Port 1 is applied last so it wins an address collision.
   always_comb begin
      regs_d = regs_q;
      if (w0_wr) regs_d[w0_addr] = w0_data;
      if (w1_wr) regs_d[w1_addr] = w1_data;
      regs_d[0] = '0;
   end

   always_comb begin
      clr_mask = '0;
      set_mask = '0;
      if (w0_wr)   clr_mask[w0_addr]   = 1'b1;
      if (w1_wr)   clr_mask[w1_addr]   = 1'b1;
      if (mark_wr) set_mask[mark_addr] = 1'b1;
   end

   // A new producer marked in the same cycle as the old one retires keeps the register busy.
   always_comb begin
      busy_clr    = busy_q & ~clr_mask;
      busy_d      = busy_clr | set_mask;
      busy_clr[0] = 1'b0;
      busy_d[0]   = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= '0;
         busy_q     <= '0;
         busy_any_q <= 1'b0;
      end else begin
         for (int r = 0; r < NREGS; r++) regs_q[r] <= regs_d[r];
         busy_q     <= busy_d;
         busy_any_q <= |busy_d;
      end
   end

   assign busy_any = busy_any_q;

   for (genvar i = 0; i < NREAD; i++) begin : g_rd
      logic [REG_ADDR_WIDTH-1:0] addr;
      logic [WORD_WIDTH-1:0]     dat_d;
      logic [WORD_WIDTH-1:0]     dat_q;
      logic                      bsy_d;
      logic                      bsy_q;

      assign addr = ra[i*REG_ADDR_WIDTH +: REG_ADDR_WIDTH];

      always_comb begin
         dat_d = regs_q[addr];
         bsy_d = busy_q[addr];
         if (BYPASS) begin
            if (w0_wr && (w0_addr == addr)) dat_d = w0_data;
            if (w1_wr && (w1_addr == addr)) dat_d = w1_data;
            bsy_d = busy_clr[addr];
         end
         if (addr == '0) begin
            dat_d = '0;
            bsy_d = 1'b0;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            dat_q <= '0;
            bsy_q <= 1'b0;
         end else begin
            dat_q <= dat_d;
            bsy_q <= bsy_d;
         end
      end

      assign rd[i*WORD_WIDTH +: WORD_WIDTH] = dat_q;
      assign rd_busy[i]                     = bsy_q;
   end

endmodule
